ex_muldiv_stage: RTL and testbench
==================================

Name: ex_muldiv_stage

Overview:
- Execute stage of the MIPS32 5-stage pipeline; consumes the registered ALU opcode, operands and write-back tag produced by the ID/EX pipeline register.
- Computes ALU, shift and multiply results and owns the HI/LO registers.
- Contains an iterative radix-2 divider that holds the pipeline via stall_req_o.
- Registers its result into the EX/MEM boundary. Outputs are flopped; this block is the EX stage plus the EX/MEM register.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles; must equal the operand width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- ALUop_i  input  5  opcode from ID/EX; encodings are listed in Decomposition.
- oprand1_i  input  32  operand 1 (rs value).
- oprand2_i  input  32  operand 2 (rt value or extended immediate; shift amount in bits [4:0]).
- writeAddr_i  input  5  destination register.
- writeEnable_i  input  1  destination write enable.
- stall_req_o  output  1  combinational; high while a DIV/DIVU is unfinished; the pipeline controller freezes PC, IF/ID and ID/EX while it is high.
- writeAddr_o  output  5  registered destination to MEM.
- writeEnable_o  output  1  registered write enable to MEM.
- writeData_o  output  32  registered result to MEM.
- hi_o  output  32  current HI register.
- lo_o  output  32  current LO register.

Behaviour:
- Reset: writeAddr_o=0, writeEnable_o=0, writeData_o=0, HI=0, LO=0, FSM=IDLE, iteration counter=0. stall_req_o=0 in the cycle after reset.
- Reset during a division aborts it. HI/LO are cleared, not written with a partial result.
- Single-cycle ops, latency 1: the result appears on the outputs at the clk edge after the op is presented.
- AND, OR, XOR, NOR: bitwise.
- ADD, SUB: mod 2^32, no trap.
- SLT: signed compare; SLTU: unsigned compare; result 0 or 1.
- SLL, SRL, SRA: shift oprand2_i by oprand1_i[4:0].
- MFHI, MFLO: result is HI or LO. A value written to HI/LO on edge N is visible to an MFHI/MFLO presented in cycle N+1; no stale read.
- MTHI, MTLO: HI or LO <= oprand1_i.
- NOP: writeEnable_o=0.
- MULT, MULTU: {HI,LO} <= 64-bit signed or unsigned product in one cycle.
- MTHI, MTLO, MULT, MULTU, DIV and DIVU drive writeEnable_o=0 regardless of writeEnable_i.
- Divider FSM states IDLE, RUN, DONE:
  - IDLE + DIV/DIVU presented: latch magnitudes and result signs; counter=0; go RUN; stall_req_o=1.
  - RUN: one restoring shift-subtract step per cycle; counter+1; after DIV_CYCLES steps go DONE; stall_req_o=1.
  - DONE: stall_req_o=0; HI <= remainder, LO <= quotient at this edge; go IDLE.
  - Total stall 33 cycles for DIV_CYCLES=32; the instruction occupies EX for 34 cycles.
- While stall_req_o=1 the EX/MEM outputs carry a bubble: writeEnable_o=0, writeAddr_o=0, writeData_o=0.
- DIV sign rules: the quotient is negative iff the operand signs differ. The remainder takes the dividend's sign. -2^31 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero (divisor 0), both DIV and DIVU: LO=0xFFFFFFFF, HI=dividend. Still takes the full 34 cycles.
- Inputs are sampled only in IDLE. ALUop_i changes during RUN are ignored, since upstream is frozen anyway.

Optional Feature:
- Macro EX_OVF_TRAP_EN.
- Defined:
  - Adds output ovf_o (1 bit, registered, reset 0).
  - Signed overflow on ADD or SUB sets ovf_o=1 for one cycle and forces writeEnable_o=0.
  - ADDU and SUBU (extra encodings) never trap.
- Undefined:
  - No ovf_o port.
  - ADDU/SUBU decode identically to ADD/SUB; ADD/SUB always write.

Decomposition:
- Shared defines file holds the ALU_* opcode constants:
  - NOP=00, AND=01, OR=02, XOR=03, NOR=04, ADD=05, SUB=06, SLT=07, SLTU=08.
  - SLL=09, SRL=0A, SRA=0B, MULT=0C, MULTU=0D, DIV=0E, DIVU=0F.
  - MFHI=10, MFLO=11, MTHI=12, MTLO=13, ADDU=14, SUBU=15.
- The divider FSM state encodings go in the same file.
- One natural sub-module, div_iter: the divider with start/done handshake, signed fix-up and the divide-by-zero rule.

Test Plan:
- Reset held 3 cycles mid-stream -> all outputs 0, hi_o=lo_o=0, stall_req_o=0.
- ADD op1=0x7FFFFFFF, op2=1, waddr=5, we=1 -> next cycle writeData_o=0x80000000, writeAddr_o=5, writeEnable_o=1. With EX_OVF_TRAP_EN: ovf_o=1 and writeEnable_o=0.
- SRA op1=4, op2=0xF0000000 -> 0xFF000000. SLTU op1=1, op2=0xFFFFFFFF -> 1. SLT with the same operands -> 0.
- MULT 0xFFFFFFFE x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then MFLO next cycle -> writeData_o=0xFFFFFFFA.
- DIV -7 / 2 -> stall_req_o high exactly 33 cycles, bubbles on the outputs, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 10/0 -> LO=0xFFFFFFFF, HI=10.
- DIV started, then rst asserted at RUN cycle 10 -> FSM IDLE, stall_req_o=0, HI=LO=0 next cycle.

Source files
------------

// File: rtl/ex_muldiv_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcode encodings and divider FSM states.
package ex_muldiv_stage_pkg;

    localparam logic [4:0] ALU_NOP   = 5'h00;
    localparam logic [4:0] ALU_AND   = 5'h01;
    localparam logic [4:0] ALU_OR    = 5'h02;
    localparam logic [4:0] ALU_XOR   = 5'h03;
    localparam logic [4:0] ALU_NOR   = 5'h04;
    localparam logic [4:0] ALU_ADD   = 5'h05;
    localparam logic [4:0] ALU_SUB   = 5'h06;
    localparam logic [4:0] ALU_SLT   = 5'h07;
    localparam logic [4:0] ALU_SLTU  = 5'h08;
    localparam logic [4:0] ALU_SLL   = 5'h09;
    localparam logic [4:0] ALU_SRL   = 5'h0A;
    localparam logic [4:0] ALU_SRA   = 5'h0B;
    localparam logic [4:0] ALU_MULT  = 5'h0C;
    localparam logic [4:0] ALU_MULTU = 5'h0D;
    localparam logic [4:0] ALU_DIV   = 5'h0E;
    localparam logic [4:0] ALU_DIVU  = 5'h0F;
    localparam logic [4:0] ALU_MFHI  = 5'h10;
    localparam logic [4:0] ALU_MFLO  = 5'h11;
    localparam logic [4:0] ALU_MTHI  = 5'h12;
    localparam logic [4:0] ALU_MTLO  = 5'h13;
    localparam logic [4:0] ALU_ADDU  = 5'h14;
    localparam logic [4:0] ALU_SUBU  = 5'h15;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_muldiv_stage_div_iter.sv
// Iterative restoring radix-2 divider (one quotient bit per cycle) with
// signed fix-up and the divide-by-zero result rule (LO=all ones, HI=dividend).
module div_iter
    import ex_muldiv_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             stall_o,
    output logic             idle_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             negQ_q, negQ_d;
    logic             negR_q, negR_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH:0]   remShift, trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            negQ_q     <= negQ_d;
            negR_q     <= negR_d;
            divZero_q  <= divZero_d;
        end
    end

    // The dividend magnitude is shifted out of quot_q MSB-first while quotient bits shift in.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        negQ_d     = negQ_q;
        negR_d     = negR_q;
        divZero_d  = divZero_q;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        remShift   = {rem_q, quot_q[WIDTH-1]};
        trial      = remShift - {1'b0, divisor_q};
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    stall_o    = 1'b1;
                    state_d    = DIV_RUN;
                    cnt_d      = '0;
                    rem_d      = '0;
                    quot_d     = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                    divisor_d  = (signed_i && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
                    dividend_d = dividend_i;
                    negQ_d     = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    negR_d     = signed_i && dividend_i[WIDTH-1];
                    divZero_d  = (divisor_i == '0);
                end
            end
            DIV_RUN: begin
                stall_o = 1'b1;
                rem_d   = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
                quot_d  = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done_o  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign idle_o      = (state_q == DIV_IDLE);
    assign quotient_o  = divZero_q ? '1 : (negQ_q ? -quot_q : quot_q);
    assign remainder_o = divZero_q ? dividend_q : (negR_q ? -rem_q : rem_q);

endmodule

// File: rtl/ex_muldiv_stage.sv
// MIPS32 EX stage plus EX/MEM register: ALU, shifts, multiply, HI/LO and divider.
// Define EX_OVF_TRAP_EN to add ovf_o and suppress the write on signed ADD/SUB overflow.
module ex_muldiv_stage
    import ex_muldiv_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUop_i,
    input  logic [31:0] oprand1_i,
    input  logic [31:0] oprand2_i,
    input  logic [4:0]  writeAddr_i,
    input  logic        writeEnable_i,
    output logic        stall_req_o,
    output logic [4:0]  writeAddr_o,
    output logic        writeEnable_o,
    output logic [31:0] writeData_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
`ifdef EX_OVF_TRAP_EN
    ,
    output logic        ovf_o
`endif
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] writeData_q, writeData_d;
    logic [4:0]  writeAddr_q, writeAddr_d;
    logic        writeEnable_q, writeEnable_d;
`ifdef EX_OVF_TRAP_EN
    logic        ovf_q, ovf_d;
`endif

    logic [31:0] sum, diff, divQuot, divRem;
    logic [63:0] mulA, mulB, product;
    logic [4:0]  shamt;
    logic        mulSigned, isDiv, divStall, divIdle, divDone;

    assign shamt     = oprand1_i[4:0];
    assign sum       = oprand1_i + oprand2_i;
    assign diff      = oprand1_i - oprand2_i;
    assign mulSigned = (ALUop_i == ALU_MULT);
    assign mulA      = {{32{mulSigned & oprand1_i[31]}}, oprand1_i};
    assign mulB      = {{32{mulSigned & oprand2_i[31]}}, oprand2_i};
    assign product   = mulA * mulB;
    assign isDiv     = (ALUop_i == ALU_DIV) || (ALUop_i == ALU_DIVU);

    div_iter #(.WIDTH(DIV_CYCLES)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (isDiv),
        .signed_i    (ALUop_i == ALU_DIV),
        .dividend_i  (oprand1_i),
        .divisor_i   (oprand2_i),
        .stall_o     (divStall),
        .idle_o      (divIdle),
        .done_o      (divDone),
        .quotient_o  (divQuot),
        .remainder_o (divRem)
    );

    always_comb begin
        writeData_d   = '0;
        writeAddr_d   = writeAddr_i;
        writeEnable_d = writeEnable_i;
        hi_d          = hi_q;
        lo_d          = lo_q;
`ifdef EX_OVF_TRAP_EN
        ovf_d         = 1'b0;
`endif
        case (ALUop_i)
            ALU_AND:  writeData_d = oprand1_i & oprand2_i;
            ALU_OR:   writeData_d = oprand1_i | oprand2_i;
            ALU_XOR:  writeData_d = oprand1_i ^ oprand2_i;
            ALU_NOR:  writeData_d = ~(oprand1_i | oprand2_i);
            ALU_ADD, ALU_ADDU: begin
                writeData_d = sum;
`ifdef EX_OVF_TRAP_EN
                ovf_d = (ALUop_i == ALU_ADD) && (oprand1_i[31] == oprand2_i[31])
                        && (sum[31] != oprand1_i[31]);
`endif
            end
            ALU_SUB, ALU_SUBU: begin
                writeData_d = diff;
`ifdef EX_OVF_TRAP_EN
                ovf_d = (ALUop_i == ALU_SUB) && (oprand1_i[31] != oprand2_i[31])
                        && (diff[31] != oprand1_i[31]);
`endif
            end
            ALU_SLT:  writeData_d = {31'd0, $signed(oprand1_i) < $signed(oprand2_i)};
            ALU_SLTU: writeData_d = {31'd0, oprand1_i < oprand2_i};
            ALU_SLL:  writeData_d = oprand2_i << shamt;
            ALU_SRL:  writeData_d = oprand2_i >> shamt;
            ALU_SRA:  writeData_d = $unsigned($signed(oprand2_i) >>> shamt);
            ALU_MFHI: writeData_d = hi_q;
            ALU_MFLO: writeData_d = lo_q;
            ALU_MTHI: begin
                writeEnable_d = 1'b0;
                hi_d          = oprand1_i;
            end
            ALU_MTLO: begin
                writeEnable_d = 1'b0;
                lo_d          = oprand1_i;
            end
            ALU_MULT, ALU_MULTU: begin
                writeEnable_d = 1'b0;
                {hi_d, lo_d}  = product;
            end
            default: writeEnable_d = 1'b0;
        endcase
`ifdef EX_OVF_TRAP_EN
        if (ovf_d) begin
            writeEnable_d = 1'b0;
        end
`endif
        // A divide in flight owns the stage: emit a bubble and ignore whatever ALUop_i shows.
        if (!divIdle || divStall) begin
            writeData_d   = '0;
            writeAddr_d   = '0;
            writeEnable_d = 1'b0;
            hi_d          = hi_q;
            lo_d          = lo_q;
`ifdef EX_OVF_TRAP_EN
            ovf_d         = 1'b0;
`endif
        end
        if (divDone) begin
            hi_d = divRem;
            lo_d = divQuot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q          <= '0;
            lo_q          <= '0;
            writeData_q   <= '0;
            writeAddr_q   <= '0;
            writeEnable_q <= 1'b0;
`ifdef EX_OVF_TRAP_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            writeData_q   <= writeData_d;
            writeAddr_q   <= writeAddr_d;
            writeEnable_q <= writeEnable_d;
`ifdef EX_OVF_TRAP_EN
            ovf_q         <= ovf_d;
`endif
        end
    end

    assign stall_req_o   = divStall;
    assign writeData_o   = writeData_q;
    assign writeAddr_o   = writeAddr_q;
    assign writeEnable_o = writeEnable_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
`ifdef EX_OVF_TRAP_EN
    assign ovf_o         = ovf_q;
`endif

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic model of the EX stage.
module tb_ex_muldiv_stage;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_AND   = 5'h01;
    localparam logic [4:0] OP_OR    = 5'h02;
    localparam logic [4:0] OP_XOR   = 5'h03;
    localparam logic [4:0] OP_NOR   = 5'h04;
    localparam logic [4:0] OP_ADD   = 5'h05;
    localparam logic [4:0] OP_SUB   = 5'h06;
    localparam logic [4:0] OP_SLT   = 5'h07;
    localparam logic [4:0] OP_SLTU  = 5'h08;
    localparam logic [4:0] OP_SLL   = 5'h09;
    localparam logic [4:0] OP_SRL   = 5'h0A;
    localparam logic [4:0] OP_SRA   = 5'h0B;
    localparam logic [4:0] OP_MULT  = 5'h0C;
    localparam logic [4:0] OP_MULTU = 5'h0D;
    localparam logic [4:0] OP_DIV   = 5'h0E;
    localparam logic [4:0] OP_DIVU  = 5'h0F;
    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MFLO  = 5'h11;
    localparam logic [4:0] OP_MTHI  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;
    localparam logic [4:0] OP_ADDU  = 5'h14;
    localparam logic [4:0] OP_SUBU  = 5'h15;
    localparam int DIVC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  aluOp;
    logic [31:0] op1, op2;
    logic [4:0]  wAddr;
    logic        wEn;
    logic        stall_req_o, writeEnable_o;
    logic [4:0]  writeAddr_o;
    logic [31:0] writeData_o, hi_o, lo_o;
`ifdef EX_OVF_TRAP_EN
    logic        ovf_o;
`endif

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ex_muldiv_stage #(.DIV_CYCLES(DIVC)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALUop_i       (aluOp),
        .oprand1_i     (op1),
        .oprand2_i     (op2),
        .writeAddr_i   (wAddr),
        .writeEnable_i (wEn),
        .stall_req_o   (stall_req_o),
        .writeAddr_o   (writeAddr_o),
        .writeEnable_o (writeEnable_o),
        .writeData_o   (writeData_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
`ifdef EX_OVF_TRAP_EN
        ,
        .ovf_o         (ovf_o)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Model state: architectural HI/LO, the expected EX/MEM contents and a divide in progress.
    logic        modelValid = 1'b0;
    logic [31:0] mHi, mLo, expData, pendQ, pendR;
    logic [4:0]  expAddr;
    logic        expWe, expFull, expOvf;
    bit          divBusy;
    int          divCyc;

    task automatic modelBubble();
        expData = '0; expAddr = '0; expWe = 1'b0; expFull = 1'b1; expOvf = 1'b0;
    endtask

    task automatic modelDivide();
        longint a, b;
        if (op2 == 32'd0) begin
            pendQ = 32'hFFFFFFFF;
            pendR = op1;
        end else begin
            a = (aluOp == OP_DIV) ? longint'($signed(op1)) : longint'(op1);
            b = (aluOp == OP_DIV) ? longint'($signed(op2)) : longint'(op2);
            pendQ = 32'(a / b);
            pendR = 32'(a % b);
        end
    endtask

    task automatic modelSingle();
        logic [31:0] r;
        logic [63:0] p;
        longint      s;
        bit          wr, ovf;
        r = '0; wr = 1'b1; ovf = 1'b0; s = 0;
        case (aluOp)
            OP_AND:  r = op1 & op2;
            OP_OR:   r = op1 | op2;
            OP_XOR:  r = op1 ^ op2;
            OP_NOR:  r = ~(op1 | op2);
            OP_ADD: begin
                r = op1 + op2;
                s = longint'($signed(op1)) + longint'($signed(op2));
`ifdef EX_OVF_TRAP_EN
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
            end
            OP_SUB: begin
                r = op1 - op2;
                s = longint'($signed(op1)) - longint'($signed(op2));
`ifdef EX_OVF_TRAP_EN
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
            end
            OP_ADDU: r = op1 + op2;
            OP_SUBU: r = op1 - op2;
            OP_SLT:  r = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (op1 < op2) ? 32'd1 : 32'd0;
            OP_SLL:  r = op2 << op1[4:0];
            OP_SRL:  r = op2 >> op1[4:0];
            OP_SRA:  r = $signed(op2) >>> op1[4:0];
            OP_MFHI: r = mHi;
            OP_MFLO: r = mLo;
            OP_MTHI: begin wr = 1'b0; mHi = op1; end
            OP_MTLO: begin wr = 1'b0; mLo = op1; end
            OP_MULT: begin
                wr = 1'b0;
                p = longint'($signed(op1)) * longint'($signed(op2));
                mHi = p[63:32]; mLo = p[31:0];
            end
            OP_MULTU: begin
                wr = 1'b0;
                p = {32'd0, op1} * {32'd0, op2};
                mHi = p[63:32]; mLo = p[31:0];
            end
            default: wr = 1'b0;
        endcase
        expData = r; expAddr = wAddr; expFull = wr;
        expWe = wr && wEn && !ovf; expOvf = ovf;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mHi = '0; mLo = '0; divBusy = 0; divCyc = 0;
            modelBubble();
        end else if (divBusy) begin
            modelBubble();
            if (divCyc == DIVC + 1) begin
                mHi = pendR; mLo = pendQ; divBusy = 0;
            end else begin
                divCyc++;
            end
        end else if (aluOp == OP_DIV || aluOp == OP_DIVU) begin
            modelBubble();
            modelDivide();
            divBusy = 1; divCyc = 1;
        end else begin
            modelSingle();
        end
        modelValid = 1'b1;
    end

    always @(negedge clk) begin
        logic expStall;
        if (modelValid) begin
            expStall = divBusy ? (divCyc <= DIVC) : (aluOp == OP_DIV || aluOp == OP_DIVU);
            checkOutput("model_stall", {31'd0, stall_req_o}, {31'd0, expStall});
            checkOutput("model_we", {31'd0, writeEnable_o}, {31'd0, expWe});
            checkOutput("model_hi", hi_o, mHi);
            checkOutput("model_lo", lo_o, mLo);
            if (expFull) begin
                checkOutput("model_addr", {27'd0, writeAddr_o}, {27'd0, expAddr});
                checkOutput("model_data", writeData_o, expData);
            end
`ifdef EX_OVF_TRAP_EN
            checkOutput("model_ovf", {31'd0, ovf_o}, {31'd0, expOvf});
`endif
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] addr, input logic en);
        aluOp = op; op1 = a; op2 = b; wAddr = addr; wEn = en;
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        applyStimulus(op, a, b, 5'd3, 1'b1);
        checkOutput(name, writeData_o, expected);
    endtask

    task automatic runDiv(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expQ, input logic [31:0] expR);
        int stallCount;
        stallCount = 0;
        aluOp = op; op1 = a; op2 = b; wAddr = 5'd9; wEn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req_o) break;
            stallCount++;
        end
        checkOutput({name, "_stall_cycles"}, 32'(stallCount), 32'd33);
        @(posedge clk);
        #1;
        aluOp = OP_NOP;
        checkOutput({name, "_lo"}, lo_o, expQ);
        checkOutput({name, "_hi"}, hi_o, expR);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_data"}, writeData_o, 32'd0);
        checkOutput({name, "_addr"}, {27'd0, writeAddr_o}, 32'd0);
        checkOutput({name, "_we"}, {31'd0, writeEnable_o}, 32'd0);
        checkOutput({name, "_hi"}, hi_o, 32'd0);
        checkOutput({name, "_lo"}, lo_o, 32'd0);
        checkOutput({name, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; aluOp = OP_NOP; op1 = '0; op2 = '0; wAddr = '0; wEn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
        checkOutput("add_data", writeData_o, 32'h80000000);
        checkOutput("add_addr", {27'd0, writeAddr_o}, 32'd5);
`ifdef EX_OVF_TRAP_EN
        checkOutput("add_we", {31'd0, writeEnable_o}, 32'd0);
        checkOutput("add_ovf", {31'd0, ovf_o}, 32'd1);
`else
        checkOutput("add_we", {31'd0, writeEnable_o}, 32'd1);
`endif

        runVec("and",  OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        runVec("or",   OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
        runVec("xor",  OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        runVec("nor",  OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F);
        runVec("sub",  OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE);
        runVec("subv", OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF);
        runVec("subu", OP_SUBU, 32'h80000000, 32'd1,        32'h7FFFFFFF);
        runVec("addu", OP_ADDU, 32'h7FFFFFFF, 32'd1,        32'h80000000);
        runVec("sll",  OP_SLL,  32'h00000021, 32'd1,        32'd2);
        runVec("srl",  OP_SRL,  32'd4,        32'hF0000000, 32'h0F000000);
        runVec("sra",  OP_SRA,  32'd4,        32'hF0000000, 32'hFF000000);
        runVec("sltu", OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1);
        runVec("slt",  OP_SLT,  32'd1,        32'hFFFFFFFF, 32'd0);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 5'd4, 1'b1);
        checkOutput("mult_hi", hi_o, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo_o, 32'hFFFFFFFA);
        checkOutput("mult_we", {31'd0, writeEnable_o}, 32'd0);
        runVec("mflo", OP_MFLO, 32'd0, 32'd0, 32'hFFFFFFFA);
        runVec("mfhi", OP_MFHI, 32'd0, 32'd0, 32'hFFFFFFFF);
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1);
        checkOutput("multu_hi", hi_o, 32'hFFFFFFFE);
        checkOutput("multu_lo", lo_o, 32'h00000001);
        applyStimulus(OP_MTHI, 32'h12345678, 32'd0, 5'd6, 1'b1);
        checkOutput("mthi_we", {31'd0, writeEnable_o}, 32'd0);
        runVec("mfhi_fwd", OP_MFHI, 32'd0, 32'd0, 32'h12345678);
        applyStimulus(OP_MTLO, 32'hCAFEF00D, 32'd0, 5'd6, 1'b1);
        runVec("mflo_fwd", OP_MFLO, 32'd0, 32'd0, 32'hCAFEF00D);

        rst = 1'b1; aluOp = OP_NOP;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("midreset");
        rst = 1'b0;

        runDiv("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
        runDiv("divu_z",   OP_DIVU, 32'd10,       32'd0,        32'hFFFFFFFF, 32'd10);
        runDiv("div_min",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        runDiv("div_z",    OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9);
        runDiv("divu",     OP_DIVU, 32'd100,      32'd7,        32'd14,       32'd2);
        runDiv("div_dpos", OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        runVec("mflo_div", OP_MFLO, 32'd0, 32'd0, 32'hFFFFFFFD);

        aluOp = OP_DIV; op1 = 32'd100; op2 = 32'd7; wAddr = 5'd9; wEn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_stall_before", {31'd0, stall_req_o}, 32'd1);
        rst = 1'b1; aluOp = OP_NOP;
        @(posedge clk);
        #1;
        checkAllZero("abort");
        rst = 1'b0;
        runVec("post_abort", OP_ADDU, 32'd3, 32'd4, 32'd7);

        applyStimulus(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
